// File: rtl/param_fifo_pkg.sv
// Shared definitions for the parametrised FIFO: default sizes, level width helper, status bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package param_fifo_pkg;

  localparam int PARAM_FIFO_DEF_WIDTH = 4;
  localparam int PARAM_FIFO_DEF_DEPTH = 10;

  // Width needed to hold every level value from 0 to depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Status flags, all derived from the registered fill level.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/param_fifo_if.sv
// Producer/consumer handshake bundle plus fill status for param_fifo (PARAM_FIFO_WMARK_EN adds max_level).
// Latency: n/a (wires only).
// Backpressure: in_ready/out_valid carry the FIFO's full/empty backpressure.
interface param_fifo_if
  import param_fifo_pkg::*;
#(
  parameter int WIDTH = PARAM_FIFO_DEF_WIDTH,
  parameter int DEPTH = PARAM_FIFO_DEF_DEPTH
);
  localparam int LW = lvl_w(DEPTH);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [LW-1:0]    level;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
`ifdef PARAM_FIFO_WMARK_EN
  logic [LW-1:0]    max_level;
`endif

  // Environment side: drives the producer/consumer controls, observes the FIFO.
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level,
           full, empty, almost_full, almost_empty
`ifdef PARAM_FIFO_WMARK_EN
    , input max_level
`endif
  );

  // FIFO side.
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level,
           full, empty, almost_full, almost_empty
`ifdef PARAM_FIFO_WMARK_EN
    , output max_level
`endif
  );

endinterface

// File: rtl/param_fifo_ptr.sv
// Wrap-around index register counting 0..DEPTH-1, for any DEPTH (not just powers of two).
// Latency: advances on the edge where inc is sampled high.
// Backpressure: none; rst/clr override inc.
module param_fifo_ptr #(
  parameter int DEPTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  // Clear to zero, otherwise step and wrap explicitly from the last slot back to zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + ONE;
    end
  end

endmodule

// File: rtl/param_fifo.sv
// Synchronous show-ahead FIFO with level counter, almost thresholds and flush; PARAM_FIFO_WMARK_EN adds a peak-level register.
// Latency: 1 cycle write-to-read; status flags follow the causing edge by one cycle.
// Backpressure: in_ready = !full (no pass-through when full), out_valid = !empty (no bypass when empty).
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int WIDTH     = PARAM_FIFO_DEF_WIDTH,
  parameter int DEPTH     = PARAM_FIFO_DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input logic        clk,
  input logic        rst,
  param_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  localparam logic [LW-1:0] ONE    = LW'(1);
  localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L   = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L   = LW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic [LW-1:0]    level_nxt;
  logic             push;
  logic             pop;
  logic             clr;
  fifo_status_t     stat;

  // Flush is a plain synchronous clear; reset is handled alongside it everywhere.
  assign clr  = bus.flush;
  assign push = bus.in_valid && !stat.full;
  assign pop  = bus.out_ready && !stat.empty;

  param_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (push),
    .ptr (wr_ptr)
  );

  param_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (pop),
    .ptr (rd_ptr)
  );

  // Store accepted data; a push coinciding with reset or flush is dropped. Storage itself is never cleared.
  always_ff @(posedge clk) begin
    if (push && !rst && !clr) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // Next fill level: clear wins, push+pop cancels out.
  always_comb begin
    level_nxt = level;
    if (rst || clr) begin
      level_nxt = '0;
    end else if (push && !pop) begin
      level_nxt = level + ONE;
    end else if (pop && !push) begin
      level_nxt = level - ONE;
    end
  end

  // Fill level register.
  always_ff @(posedge clk) begin
    level <= level_nxt;
  end

  // All flags come from the registered level, so they settle one cycle after the causing edge.
  always_comb begin
    stat.full         = (level == FULL_L);
    stat.empty        = (level == '0);
    stat.almost_full  = (level >= AF_L);
    stat.almost_empty = (level <= AE_L);
  end

  assign bus.level        = level;
  assign bus.full         = stat.full;
  assign bus.empty        = stat.empty;
  assign bus.almost_full  = stat.almost_full;
  assign bus.almost_empty = stat.almost_empty;
  assign bus.in_ready     = !stat.full;
  assign bus.out_valid    = !stat.empty;
  assign bus.out_data     = mem[rd_ptr];

`ifdef PARAM_FIFO_WMARK_EN
  logic [LW-1:0] max_level;

  // Track the highest level seen since the last reset or flush.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      max_level <= '0;
    end else if (level_nxt > max_level) begin
      max_level <= level_nxt;
    end
  end

  assign bus.max_level = max_level;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo: directed plan followed by randomized traffic with flush/reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_param_fifo;
  import param_fifo_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEPTH = 10;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [WIDTH-1:0] sb_q[$];
  int mdl_lvl = 0;
  int mdl_max = 0;

  param_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  param_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever the DUT hands out a word that the consumer takes, compare with the oldest expected word.
  always @(negedge clk) begin : monitor
    logic [WIDTH-1:0] e;
    if (!rst && !bus.flush && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_underflow: got data %0d expected no output at %0t", bus.out_data, $time);
      end else begin
        e = sb_q.pop_front();
        chk("out_data", int'(bus.out_data), int'(e));
      end
    end
  end

  // One clock of stimulus: drive, check status against the model mid-cycle, then advance the model at the edge.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
    bit push_ok;
    bit pop_ok;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    bus.flush     = f;
    @(negedge clk);
    chk("level",        int'(bus.level),        mdl_lvl);
    chk("full",         int'(bus.full),         int'(mdl_lvl == DEPTH));
    chk("empty",        int'(bus.empty),        int'(mdl_lvl == 0));
    chk("almost_full",  int'(bus.almost_full),  int'(mdl_lvl >= AF));
    chk("almost_empty", int'(bus.almost_empty), int'(mdl_lvl <= AE));
    chk("in_ready",     int'(bus.in_ready),     int'(mdl_lvl != DEPTH));
    chk("out_valid",    int'(bus.out_valid),    int'(mdl_lvl != 0));
`ifdef PARAM_FIFO_WMARK_EN
    chk("max_level",    int'(bus.max_level),    mdl_max);
`endif
    push_ok = v && (mdl_lvl < DEPTH);
    pop_ok  = r && (mdl_lvl > 0);
    @(posedge clk);
    if (rst || f) begin
      mdl_lvl = 0;
      mdl_max = 0;
      sb_q.delete();
    end else begin
      if (push_ok) sb_q.push_back(d);
      mdl_lvl = mdl_lvl + int'(push_ok) - int'(pop_ok);
      if (mdl_lvl > mdl_max) mdl_max = mdl_lvl;
    end
    #1;
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [WIDTH-1:0] val;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b0);

    // Fill with 1..10, then offer 11 to a full FIFO.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
    cycle(1'b1, WIDTH'(11), 1'b0, 1'b0);
    cycle(1'b1, WIDTH'(11), 1'b0, 1'b0);

    // Drain completely, plus one idle to observe empty.
    drain(DEPTH);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Pointer wrap: 7 in, 7 out, then 0xA..0xF,0x0..0x3 across the 9->0 boundary.
    fill_rand(7);
    drain(7);
    for (int i = 0; i < DEPTH; i++) begin
      val = WIDTH'(10 + i);
      cycle(1'b1, val, 1'b0, 1'b0);
    end
    drain(DEPTH);

    // Steady push+pop at level 5.
    fill_rand(5);
    for (int i = 0; i < 20; i++) cycle(1'b1, WIDTH'($urandom), 1'b1, 1'b0);
    // At full, push+pop only pops.
    fill_rand(5);
    cycle(1'b1, WIDTH'($urandom), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    drain(DEPTH);

    // Flush at level 6 with a concurrent push.
    fill_rand(6);
    cycle(1'b1, WIDTH'(5), 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      cycle(1'($urandom_range(0, 3) != 0), WIDTH'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) == 0));
    end
    rst = 1'b0;

    // Drain leftovers and confirm every pushed word was delivered.
    drain(DEPTH + 1);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
